switch_sequencer: RTL and testbench

SWITCH_SEQUENCER -- requirements
Module: switch_sequencer

---
 rtl/switch_sequencer.sv | 105 ++++++++++
 tb/tb_switch_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/switch_sequencer.sv
// Debounces five slide switches and two push-buttons, and steps a 0..4 selection index from the buttons.
// Input-to-debounced latency is 2+DB_LEN edges; the selection updates on the same edge its button debounces high.
module switch_sequencer #(
   parameter int DB_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] sw_raw,
   input  logic       btn_step,
   input  logic       btn_back,
   output logic [4:0] left_in,
   output logic [2:0] sel,
   output logic       sel_changed
);

   localparam int CW = ($clog2(DB_LEN) < 1) ? 1 : $clog2(DB_LEN);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN - 1);
   localparam int NB = 7;
   localparam int STEP_BIT = 5;
   localparam int BACK_BIT = 6;

   localparam logic [2:0] SEL0 = 3'd0;
   localparam logic [2:0] SEL1 = 3'd1;
   localparam logic [2:0] SEL2 = 3'd2;
   localparam logic [2:0] SEL3 = 3'd3;
   localparam logic [2:0] SEL4 = 3'd4;

   logic [NB-1:0]         raw;
   logic [NB-1:0]         sync1_q, sync1_d;
   logic [NB-1:0]         s_q, s_d;
   logic [NB-1:0]         db_q, db_d;
   logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
   logic [2:0]            sel_q, sel_d;
   logic                  chg_q, chg_d;
   logic                  step_p, back_p;

   assign raw = {btn_back, btn_step, sw_raw};

   always_comb begin
      sync1_d = raw;
      s_d     = sync1_q;
      for (int i = 0; i < NB; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (s_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i] = s_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // The debounced register itself is the edge-detect history, so a press acts on the edge it is accepted.
   assign step_p = db_d[STEP_BIT] & ~db_q[STEP_BIT];
   assign back_p = db_d[BACK_BIT] & ~db_q[BACK_BIT];

   always_comb begin
      sel_d = sel_q;
      chg_d = 1'b0;
      if (step_p && !back_p) begin
         chg_d = 1'b1;
         case (sel_q)
            SEL0:    sel_d = SEL1;
            SEL1:    sel_d = SEL2;
            SEL2:    sel_d = SEL3;
            SEL3:    sel_d = SEL4;
            default: sel_d = SEL0;
         endcase
      end else if (back_p && !step_p) begin
         chg_d = 1'b1;
         case (sel_q)
            SEL1:    sel_d = SEL0;
            SEL2:    sel_d = SEL1;
            SEL3:    sel_d = SEL2;
            SEL4:    sel_d = SEL3;
            default: sel_d = SEL4;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         s_q     <= '0;
         db_q    <= '0;
         cnt_q   <= '0;
         sel_q   <= SEL0;
         chg_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         s_q     <= s_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         chg_q   <= chg_d;
      end
   end

   assign left_in     = db_q[4:0];
   assign sel         = sel_q;
   assign sel_changed = chg_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer: expected selections are queued by the stimulus and popped by a monitor on every sel_changed strobe.
module tb_switch_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] sw_raw;
   logic       btn_step;
   logic       btn_back;
   logic [4:0] left_in;
   logic [2:0] sel;
   logic       sel_changed;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2:0] exp_q[$];

   switch_sequencer #(.DB_LEN(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_raw      (sw_raw),
      .btn_step    (btn_step),
      .btn_back    (btn_back),
      .left_in     (left_in),
      .sel         (sel),
      .sel_changed (sel_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic st, input logic bk, input int hold);
      @(negedge clk);
      btn_step = st;
      btn_back = bk;
      cyc(hold);
      btn_step = 1'b0;
      btn_back = 1'b0;
      cyc(10);
   endtask

   // Monitor: every strobe must match the next queued selection
   always @(negedge clk) begin
      if (!rst && sel_changed) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_sel_changed: got sel %0d with no pending expectation at %0t", sel, $time);
         end else begin
            check("sel_on_strobe", 32'(sel), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      sw_raw   = 5'b00000;
      btn_step = 1'b0;
      btn_back = 1'b0;
      cyc(2);
      check("reset_left_in", 32'(left_in), 32'h0);
      check("reset_sel", 32'(sel), 32'h0);
      check("reset_sel_changed", 32'(sel_changed), 32'h0);

      // Switch latency: accepted on the 6th edge
      @(negedge clk);
      rst    = 1'b0;
      sw_raw = 5'b10110;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("sw_latency_edge%0d", i), 32'(left_in), (i >= 6) ? 32'h16 : 32'h0);
      end
      check("sw_no_sel_effect", 32'(sel), 32'h0);

      @(negedge clk);
      sw_raw = 5'b00000;
      cyc(10);
      check("sw_release", 32'(left_in), 32'h0);

      // Glitch of DB_LEN-1 cycles is rejected
      sw_raw[0] = 1'b1;
      cyc(3);
      sw_raw[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("sw_glitch", 32'(left_in), 32'h0);
      end

      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(3'((k + 1) % 5));
         press(1'b1, 1'b0, 10);
      end
      check("step_wrap_sel", 32'(sel), 32'h0);
      check("step_queue_drained", 32'(exp_q.size()), 32'h0);
      check("btn_no_left_in_effect", 32'(left_in), 32'h0);

      exp_q.push_back(3'd4);
      press(1'b0, 1'b1, 10);
      check("back_wrap_sel", 32'(sel), 32'h4);

      exp_q.push_back(3'd0);
      press(1'b1, 1'b0, 50);
      check("held_step_sel", 32'(sel), 32'h0);

      press(1'b1, 1'b1, 10);
      check("both_buttons_sel", 32'(sel), 32'h0);

      for (int k = 1; k <= 3; k++) begin
         exp_q.push_back(3'(k));
         press(1'b1, 1'b0, 10);
      end
      check("pre_reset_sel", 32'(sel), 32'h3);

      // Reset mid-press: partial count discarded, held button re-debounces from scratch
      btn_step = 1'b1;
      cyc(5);
      rst = 1'b1;
      #1;
      check("async_reset_sel", 32'(sel), 32'h0);
      check("async_reset_sel_changed", 32'(sel_changed), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(3'd1);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_reset_sel_edge%0d", i), 32'(sel), (i == 6) ? 32'h1 : 32'h0);
         check($sformatf("post_reset_chg_edge%0d", i), 32'(sel_changed), (i == 6) ? 32'h1 : 32'h0);
      end
      @(negedge clk);
      btn_step = 1'b0;
      cyc(12);
      check("final_sel", 32'(sel), 32'h1);
      check("final_queue_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
